// File: rtl/afu_dma_write_engine.sv
// CCI-P channel-1 write initiator: streams num_lines patterned cache lines starting at base_addr
// and pulses done once every matching write response has come back.
module afu_dma_write_engine #(
    parameter int MAX_OUTSTANDING = 64,
    parameter int ADDR_W          = 42,
    parameter int LEN_W           = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_lines,
    input  logic [63:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              c1_tx_valid,
    output logic [ADDR_W-1:0] c1_tx_addr,
    output logic [15:0]       c1_tx_mdata,
    output logic [511:0]      c1_tx_data,
    input  logic              c1_tx_almfull,
    input  logic              c1_rx_wr_rsp_valid,
    input  logic [15:0]       c1_rx_wr_rsp_mdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] MAX_OUT = LEN_W'(MAX_OUTSTANDING);
    localparam logic [LEN_W-1:0] ONE     = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] ZERO    = {LEN_W{1'b0}};

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] base_r;
    logic [LEN_W-1:0]  num_r;
    logic [63:0]       seed_r;
    logic [LEN_W-1:0]  iss_cnt_r;
    logic [LEN_W-1:0]  rsp_cnt_r;
    logic [LEN_W-1:0]  rsp_cnt_next_s;
    logic [LEN_W-1:0]  outstanding_s;
    logic [LEN_W-1:0]  last_idx_s;
    logic              almfull_r;
    logic              start_ok_s;
    logic              issue_s;
    logic              rsp_ok_s;
    logic              rsp_err_s;
    logic              busy_r;
    logic              done_r;
    logic              error_r;
    logic              tx_valid_r;
    logic [ADDR_W-1:0] tx_addr_r;
    logic [15:0]       tx_mdata_r;
    logic [63:0]       tx_word_r;
    logic              rsp_mdata_unused_s;

    // The response tag is carried for debug visibility only.
    assign rsp_mdata_unused_s = ^c1_rx_wr_rsp_mdata;

    // Response classification, issue decision and next-state logic.
    always_comb begin
        state_next_s   = state_r;
        start_ok_s     = 1'b0;
        issue_s        = 1'b0;
        rsp_ok_s       = 1'b0;
        rsp_err_s      = 1'b0;
        outstanding_s  = iss_cnt_r - rsp_cnt_r;
        last_idx_s     = num_r - ONE;

        if (c1_rx_wr_rsp_valid) begin
            if ((state_r == ST_ISSUE || state_r == ST_DRAIN) && outstanding_s != ZERO) begin
                rsp_ok_s = 1'b1;
            end else begin
                rsp_err_s = 1'b1;
            end
        end else begin
            rsp_ok_s  = 1'b0;
            rsp_err_s = 1'b0;
        end
        rsp_cnt_next_s = rsp_ok_s ? (rsp_cnt_r + ONE) : rsp_cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    start_ok_s   = 1'b1;
                    state_next_s = (num_lines == ZERO) ? ST_DONE : ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!almfull_r && outstanding_s < MAX_OUT) begin
                    issue_s      = 1'b1;
                    state_next_s = (iss_cnt_r == last_idx_s) ? ST_DRAIN : ST_ISSUE;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                // Uses the count including this cycle's response so done follows it by one cycle.
                if (rsp_cnt_next_s == num_r) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            almfull_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            busy_r    <= (state_next_s != ST_IDLE);
            done_r    <= (state_next_s == ST_DONE);
            almfull_r <= c1_tx_almfull;
            if (rsp_err_s) begin
                error_r <= 1'b1;
            end else if (start_ok_s) begin
                error_r <= 1'b0;
            end else begin
                error_r <= error_r;
            end
        end
    end

    // Transfer parameters and issue/response counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_r    <= {ADDR_W{1'b0}};
            num_r     <= ZERO;
            seed_r    <= 64'd0;
            iss_cnt_r <= ZERO;
            rsp_cnt_r <= ZERO;
        end else if (start_ok_s) begin
            base_r    <= base_addr;
            num_r     <= num_lines;
            seed_r    <= seed;
            iss_cnt_r <= ZERO;
            rsp_cnt_r <= ZERO;
        end else begin
            iss_cnt_r <= issue_s ? (iss_cnt_r + ONE) : iss_cnt_r;
            rsp_cnt_r <= rsp_cnt_next_s;
        end
    end

    // Request register; fields hold between strobes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_valid_r <= 1'b0;
            tx_addr_r  <= {ADDR_W{1'b0}};
            tx_mdata_r <= 16'd0;
            tx_word_r  <= 64'd0;
        end else begin
            tx_valid_r <= issue_s;
            if (issue_s) begin
                tx_addr_r  <= base_r + ADDR_W'(iss_cnt_r);
                tx_mdata_r <= 16'(iss_cnt_r);
                tx_word_r  <= seed_r + 64'(iss_cnt_r);
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign error       = error_r;
    assign c1_tx_valid = tx_valid_r;
    assign c1_tx_addr  = tx_addr_r;
    assign c1_tx_mdata = tx_mdata_r;
    assign c1_tx_data  = {8{tx_word_r}};

endmodule

// File: tb/tb_afu_dma_write_engine.sv
// Self-checking bench for afu_dma_write_engine: request scoreboard, modelled responder,
// vector table of transfers plus directed backpressure, almfull, error and reset sequences.
module tb_afu_dma_write_engine;

    localparam int MAXO = 4;
    localparam int AW   = 42;
    localparam int LW   = 32;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] num_lines = '0;
    logic [63:0]   seed = '0;
    logic          busy, done, error, c1_tx_valid;
    logic [AW-1:0] c1_tx_addr;
    logic [15:0]   c1_tx_mdata;
    logic [511:0]  c1_tx_data;
    logic          c1_tx_almfull = 1'b0;
    logic          c1_rx_wr_rsp_valid = 1'b0;
    logic [15:0]   c1_rx_wr_rsp_mdata = '0;

    afu_dma_write_engine #(.MAX_OUTSTANDING(MAXO), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .num_lines(num_lines), .seed(seed), .busy(busy), .done(done), .error(error),
        .c1_tx_valid(c1_tx_valid), .c1_tx_addr(c1_tx_addr), .c1_tx_mdata(c1_tx_mdata),
        .c1_tx_data(c1_tx_data), .c1_tx_almfull(c1_tx_almfull),
        .c1_rx_wr_rsp_valid(c1_rx_wr_rsp_valid), .c1_rx_wr_rsp_mdata(c1_rx_wr_rsp_mdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   mdata;
        logic [511:0]  data;
    } req_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [LW-1:0] n;
        logic [63:0]   seed;
        int            exp_reqs;
        logic          exp_error;
    } vec_t;

    req_t        exp_q[$];
    int          pend_due[$];
    logic [15:0] pend_tag[$];

    int total = 0, bad = 0;
    int cyc = 0, tx_cnt = 0, tx_base = 0;
    int done_cnt = 0, done_cyc = -1, busy_cyc = 0, last_rsp_cyc = -1, resume_cyc = -1;
    int start_cyc = 0, rel_budget = 0;
    bit hold_rsp = 1'b0, inject_rsp = 1'b0, watch_resume = 1'b0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard requests, count done/busy, and drive responses 3 cycles after each request.
    initial begin
        req_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (c1_tx_valid) begin
                tx_cnt++;
                if (watch_resume) begin
                    resume_cyc   = cyc;
                    watch_resume = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL req_unexpected: got request addr %0h, expected none", c1_tx_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("req_addr", c1_tx_addr, e.addr);
                    check("req_mdata", c1_tx_mdata, e.mdata);
                    check("req_data", c1_tx_data, e.data);
                    pend_due.push_back(cyc + 3);
                    pend_tag.push_back(c1_tx_mdata);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_cyc++;
            c1_rx_wr_rsp_valid = 1'b0;
            if (inject_rsp) begin
                c1_rx_wr_rsp_valid = 1'b1;
                inject_rsp         = 1'b0;
            end else if (pend_due.size() > 0 && pend_due[0] <= cyc && (!hold_rsp || rel_budget > 0)) begin
                if (hold_rsp) rel_budget--;
                void'(pend_due.pop_front());
                c1_rx_wr_rsp_mdata = pend_tag.pop_front();
                c1_rx_wr_rsp_valid = 1'b1;
                last_rsp_cyc       = cyc;
            end
        end
    end

    task automatic run_start(input logic [AW-1:0] b, input logic [LW-1:0] n, input logic [63:0] s);
        req_t r;
        @(posedge clock);
        #1;
        base_addr = b;
        num_lines = n;
        seed      = s;
        start     = 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            r.addr  = b + AW'(i);
            r.mdata = 16'(i);
            r.data  = {8{s + 64'(i)}};
            exp_q.push_back(r);
        end
        start_cyc = cyc + 1;
        done_cnt  = 0;
        busy_cyc  = 0;
        tx_base   = tx_cnt;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clock);
            #1;
            if (done_cnt > 0) seen = 1'b1;
        end
        check({tag, "_done_seen"}, seen, 1'b1);
    endtask

    task automatic finish_xfer(input string tag, input int n, input logic exp_err);
        wait_done(tag);
        check({tag, "_req_count"}, tx_cnt - tx_base, n);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
        check({tag, "_error"}, error, exp_err);
        if (n > 0) check({tag, "_done_latency"}, done_cyc, last_rsp_cyc + 1);
        @(negedge clock);
        #1;
        check({tag, "_idle_after"}, {busy, done}, 2'b00);
        check({tag, "_done_once"}, done_cnt, 1);
    endtask

    initial begin
        vec_t vt[4];
        int   snap;
        int   k_deassert;
        bit   reached;

        vt[0] = '{base: 42'h100,          n: 32'd4, seed: 64'd0,                   exp_reqs: 4, exp_error: 1'b0};
        vt[1] = '{base: 42'h3FF_FFFF_FFFE, n: 32'd4, seed: 64'h0123_4567_89AB_CDEF, exp_reqs: 4, exp_error: 1'b0};
        vt[2] = '{base: 42'h2000,         n: 32'd9, seed: 64'hFFFF_FFFF_FFFF_FFFD, exp_reqs: 9, exp_error: 1'b0};
        vt[3] = '{base: 42'h55,           n: 32'd1, seed: 64'hA5A5_A5A5_A5A5_A5A5, exp_reqs: 1, exp_error: 1'b0};

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("reset_ctrl", {busy, done, error, c1_tx_valid, c1_tx_mdata, c1_tx_addr}, 512'd0);
        check("reset_data", c1_tx_data, 512'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            run_start(vt[v].base, vt[v].n, vt[v].seed);
            finish_xfer($sformatf("vec%0d", v), vt[v].exp_reqs, vt[v].exp_error);
        end

        // Zero-length transfer: straight to DONE, no requests.
        run_start(42'h40, 32'd0, 64'd7);
        repeat (4) @(negedge clock);
        #1;
        check("zero_done_cnt", done_cnt, 1);
        check("zero_done_cyc", done_cyc, start_cyc + 1);
        check("zero_busy_cycles", busy_cyc, 1);
        check("zero_no_req", tx_cnt - tx_base, 0);

        // Outstanding cap with responses withheld, then released one at a time.
        hold_rsp = 1'b1;
        run_start(42'h800, 32'd10, 64'd5);
        repeat (30) @(negedge clock);
        #1;
        check("cap_issued", tx_cnt - tx_base, MAXO);
        rel_budget = 1;
        repeat (12) @(negedge clock);
        #1;
        check("cap_one_slot", tx_cnt - tx_base, MAXO + 1);
        hold_rsp = 1'b0;
        finish_xfer("cap", 10, 1'b0);

        // Almost-full held for 20 cycles mid-transfer.
        run_start(42'h1000, 32'd30, 64'h77);
        repeat (6) @(negedge clock);
        @(posedge clock);
        #1 c1_tx_almfull = 1'b1;
        @(negedge clock);
        #1 snap = tx_cnt;
        repeat (19) @(negedge clock);
        #1;
        check("almfull_extra_le1", (tx_cnt - snap) <= 1, 1'b1);
        @(posedge clock);
        #1;
        c1_tx_almfull = 1'b0;
        k_deassert    = cyc + 1;
        watch_resume  = 1'b1;
        repeat (6) @(negedge clock);
        #1;
        check("almfull_resume", resume_cyc, k_deassert + 2);
        finish_xfer("almfull", 30, 1'b0);

        // Stray response in IDLE: sticky error, cleared by the next start.
        inject_rsp = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("err_idle", error, 1'b1);
        repeat (5) @(negedge clock);
        #1;
        check("err_sticky", {busy, error}, 2'b01);
        run_start(42'h300, 32'd3, 64'd9);
        check("err_cleared", error, 1'b0);
        finish_xfer("err_next", 3, 1'b0);

        // Asynchronous reset with 3 requests outstanding.
        hold_rsp = 1'b1;
        run_start(42'h5000, 32'd6, 64'h1111);
        reached = 1'b0;
        for (int k = 0; k < 50 && !reached; k++) begin
            @(negedge clock);
            if (tx_cnt - tx_base >= 3) reached = 1'b1;
        end
        #2 reset_n = 1'b0;
        #1;
        check("rst_pre_count", tx_cnt - tx_base, 3);
        check("rst_async_ctrl", {busy, done, error, c1_tx_valid, c1_tx_mdata, c1_tx_addr}, 512'd0);
        check("rst_async_data", c1_tx_data, 512'd0);
        exp_q.delete();
        pend_due.delete();
        pend_tag.delete();
        hold_rsp   = 1'b0;
        rel_budget = 0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        inject_rsp = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("rst_stale_rsp_err", error, 1'b1);
        run_start(42'h6000, 32'd2, 64'hDEAD);
        finish_xfer("rst_after", 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
